hpdcache_lfsr_bank: RTL

Bank of NCHAN independent Galois LFSRs used as pseudo-random sources in the cache subsystem, e.g. random victim-way selection, per-requester arbitration jitter and MSHR/refill replay back-off. It supersedes the single fixed-width LFSR. It adds:
- widths up to 32 bits;
- multiple channels;
- per-channel seed load;
- STEP shifts per advance, for decorrelating consecutive samples;
- all-zero lock-up detection and recovery.

---
 rtl/hpdcache_lfsr_pkg.sv | 48 ++++
 rtl/hpdcache_lfsr_chan.sv | 62 ++++++
 rtl/hpdcache_lfsr_bank.sv | 51 +++++
 3 files changed

// File: rtl/hpdcache_lfsr_pkg.sv
// Shared definitions for the LFSR bank: legal geometry, feedback masks and
// the single Galois step used by every channel.
package hpdcache_lfsr_pkg;

   localparam int unsigned LFSR_MIN_WIDTH   = 8;
   localparam int unsigned LFSR_MAX_NARROW  = 16;
   localparam int unsigned LFSR_WIDTH_24    = 24;
   localparam int unsigned LFSR_WIDTH_32    = 32;
   localparam int unsigned LFSR_MAX_WIDTH   = 32;
   localparam int unsigned LFSR_MIN_NCHAN   = 1;
   localparam int unsigned LFSR_MAX_NCHAN   = 8;

   function automatic logic lfsr_width_legal(input int unsigned width);
      return ((width >= LFSR_MIN_WIDTH) && (width <= LFSR_MAX_NARROW)) ||
             (width == LFSR_WIDTH_24) || (width == LFSR_WIDTH_32);
   endfunction

   // Maximal-length Galois masks; zero flags an unsupported width.
   function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_poly(input int unsigned width);
      case (width)
         8:       return 32'h0000_00E1;
         9:       return 32'h0000_01EA;
         10:      return 32'h0000_02E3;
         11:      return 32'h0000_04E3;
         12:      return 32'h0000_0AE2;
         13:      return 32'h0000_10E3;
         14:      return 32'h0000_20EA;
         15:      return 32'h0000_41E2;
         16:      return 32'h0000_81EE;
         24:      return 32'h0080_000D;
         32:      return 32'h8000_0057;
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_step(
      input logic [LFSR_MAX_WIDTH-1:0] state,
      input logic [LFSR_MAX_WIDTH-1:0] mask,
      input int unsigned               width
   );
      logic [LFSR_MAX_WIDTH:0]   w_keep;
      logic [LFSR_MAX_WIDTH-1:0] w_s;
      w_keep = (33'd1 << width) - 33'd1;
      w_s    = (state >> 1) ^ (state[0] ? mask : '0);
      return w_s & w_keep[LFSR_MAX_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/hpdcache_lfsr_chan.sv
// One LFSR channel: state register, STEP-unrolled Galois advance, seed load
// and automatic recovery from the all-zero lock-up state.
module hpdcache_lfsr_chan
   import hpdcache_lfsr_pkg::*;
#(
   parameter int unsigned          WIDTH = 16,
   parameter int unsigned          STEP  = 1,
   parameter logic [WIDTH-1:0]     SEED  = '1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             shift_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   output logic [WIDTH-1:0] val_o,
   output logic             lockup_o
);

   localparam logic [LFSR_MAX_WIDTH-1:0] MASK = lfsr_poly(WIDTH);

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] w_adv;
   logic [WIDTH-1:0] w_next;
   logic             w_zero;

   assign w_zero = (r_state == '0);

   always_comb begin
      logic [LFSR_MAX_WIDTH-1:0] w_acc;
      w_acc = LFSR_MAX_WIDTH'(r_state);
      for (int i = 0; i < int'(STEP); i++) begin
         w_acc = lfsr_step(w_acc, MASK, WIDTH);
      end
      w_adv = w_acc[WIDTH-1:0];
   end

   // A zero seed would park the channel in lock-up, so it is swapped for SEED.
   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      if (load_i) begin
         w_next = (seed_i != '0) ? seed_i : SEED;
      end else if (w_zero) begin
         w_next = SEED;
      end else if (shift_i) begin
         w_next = w_adv;
      end
   end

   // NOTE: non-blocking assignment for state so all channels update together at the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= SEED;
      end else begin
         r_state <= w_next;
      end
   end

   assign val_o    = r_state;
   assign lockup_o = w_zero;

endmodule

// File: rtl/hpdcache_lfsr_bank.sv
// Bank of NCHAN independent Galois LFSRs sharing one seed bus; used as
// pseudo-random sources for victim selection, arbitration jitter and back-off.
module hpdcache_lfsr_bank
   import hpdcache_lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter int unsigned      NCHAN = 1,
   parameter int unsigned      STEP  = 1,
   parameter logic [WIDTH-1:0] SEED  = '1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NCHAN-1:0]            shift_i,
   input  logic [NCHAN-1:0]            load_i,
   input  logic [WIDTH-1:0]            seed_i,
   output logic [NCHAN-1:0][WIDTH-1:0] val_o,
   output logic [NCHAN-1:0]            lockup_o
);

`ifndef HPDCACHE_ASSERT_OFF
   if (!lfsr_width_legal(WIDTH)) begin : g_bad_width
      $fatal(1, "hpdcache_lfsr_bank: illegal WIDTH %0d", WIDTH);
   end
   if ((NCHAN < LFSR_MIN_NCHAN) || (NCHAN > LFSR_MAX_NCHAN)) begin : g_bad_nchan
      $fatal(1, "hpdcache_lfsr_bank: illegal NCHAN %0d", NCHAN);
   end
   if ((STEP < 1) || (STEP > WIDTH)) begin : g_bad_step
      $fatal(1, "hpdcache_lfsr_bank: illegal STEP %0d", STEP);
   end
   if (SEED == '0) begin : g_bad_seed
      $fatal(1, "hpdcache_lfsr_bank: SEED must be non-zero");
   end
`endif

   for (genvar c = 0; c < int'(NCHAN); c++) begin : g_chan
      hpdcache_lfsr_chan #(
         .WIDTH (WIDTH),
         .STEP  (STEP),
         .SEED  (SEED)
      ) u_chan (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .shift_i  (shift_i[c]),
         .load_i   (load_i[c]),
         .seed_i   (seed_i),
         .val_o    (val_o[c]),
         .lockup_o (lockup_o[c])
      );
   end

endmodule
